// File: rtl/parking_pkg.sv
// Shared types and default parameters for the parking gate input stage
// and the downstream parking_system controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    HOLD    = 2'd3
  } gate_state_t;

  typedef logic [1:0] digit_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_ENTRY_TIMEOUT   = 16;

endpackage : parking_pkg

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a saturating debounce counter; the output
// toggles only after DEBOUNCE_CYCLES consecutive samples disagree with it.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_out = level_q;

endmodule : debounce_filter

// File: rtl/parking_gate_input.sv
// Conditions the gate loop sensors and captures a two-digit keypad password,
// abandoning the capture if a digit does not arrive within ENTRY_TIMEOUT cycles.
module parking_gate_input
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ENTRY_TIMEOUT   = DEF_ENTRY_TIMEOUT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   raw_entrance,
  input  logic   raw_exit,
  input  logic   key_valid,
  input  digit_t key_code,
  output logic   sensor_entrance,
  output logic   sensor_exit,
  output digit_t password_1,
  output digit_t password_2,
  output logic   pw_ready,
  output logic   pw_timeout
);

  localparam int               TMR_W    = $clog2(ENTRY_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ENTRY_TIMEOUT - 1);

  gate_state_t      state_q, state_d;
  digit_t           pw1_q, pw1_d, pw2_q, pw2_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ready_q, ready_d;
  logic             timeout_q, timeout_d;
  logic             ent_prev_q, exit_prev_q;
  logic             ent_level, exit_level;
  logic             ent_rise, exit_rise;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent_deb (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_entrance),
    .level_out (ent_level)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_exit),
    .level_out (exit_level)
  );

  assign ent_rise  = ent_level  & ~ent_prev_q;
  assign exit_rise = exit_level & ~exit_prev_q;

  always_comb begin
    state_d   = state_q;
    pw1_d     = pw1_q;
    pw2_d     = pw2_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ent_rise) begin
          state_d = WAIT_D1;
          timer_d = '0;
        end
      end
      WAIT_D1, WAIT_D2: begin
        // A new car restarts the capture; a key beats a same-cycle timeout.
        if (ent_rise) begin
          state_d = WAIT_D1;
          pw1_d   = '0;
          pw2_d   = '0;
          timer_d = '0;
        end else if (key_valid) begin
          timer_d = '0;
          if (state_q == WAIT_D1) begin
            pw1_d   = key_code;
            state_d = WAIT_D2;
          end else begin
            pw2_d   = key_code;
            state_d = HOLD;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d   = IDLE;
          pw1_d     = '0;
          pw2_d     = '0;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (ent_rise) begin
          state_d = WAIT_D1;
          pw1_d   = '0;
          pw2_d   = '0;
          timer_d = '0;
        end else if (exit_rise) begin
          state_d = IDLE;
          pw1_d   = '0;
          pw2_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pw1_q       <= '0;
      pw2_q       <= '0;
      timer_q     <= '0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      ent_prev_q  <= 1'b0;
      exit_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw1_q       <= pw1_d;
      pw2_q       <= pw2_d;
      timer_q     <= timer_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
      ent_prev_q  <= ent_level;
      exit_prev_q <= exit_level;
    end
  end

  assign sensor_entrance = ent_level;
  assign sensor_exit     = exit_level;
  assign password_1      = pw1_q;
  assign password_2      = pw2_q;
  assign pw_ready        = ready_q;
  assign pw_timeout      = timeout_q;

endmodule : parking_gate_input
